// File: rtl/serial_out.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// A one-byte holding register lets frames run back to back without an idle gap.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | line high, waiting for the holding register to fill
//   S_START  | start bit (low) for one bit period
//   S_DATA   | eight data bits, LSB first, shift register moves right
//   S_PARITY | parity over the latched byte, only when PARITY_EN=1
//   S_STOP   | stop bit (high); may hand straight over to the next start bit
module serial_out #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BYTEIN,
    input  logic       LOAD,
    output logic       READY,
    output logic       BUSY,
    output logic       OVERRUN,
    output logic       TX_D
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_hold;
    logic        r_full;
    logic        r_par;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;
    logic        r_overrun;

    state_t      w_state_next;
    logic [15:0] w_baud_next;
    logic [2:0]  w_bit_next;
    logic [7:0]  w_shift_next;
    logic [7:0]  w_hold_next;
    logic        w_full_next;
    logic        w_par_next;
    logic        w_tx_next;
    logic        w_xfer;
    logic        w_accept;
    logic        w_bit_end;

    assign w_bit_end = (r_baud == LP_LAST);
    assign w_accept  = LOAD && !r_full;

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_xfer       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_full) begin
                    w_xfer       = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_full) begin
                        w_xfer       = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (r_state == S_IDLE) w_baud_next = 16'd0;
        else if (w_bit_end)    w_baud_next = 16'd0;
        else                   w_baud_next = r_baud + 16'd1;

        if (w_xfer) w_shift_next = r_hold;

        // Transfer and accept are exclusive: a transfer needs a full register, accept an empty one.
        w_full_next = w_xfer ? 1'b0 : (w_accept ? 1'b1 : r_full);
        w_hold_next = w_accept ? BYTEIN : r_hold;
        w_par_next  = w_xfer ? ((^r_hold) ^ PARITY_ODD) : r_par;

        // The line is registered from the next state so it changes on the same edge as the state.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_par_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            r_hold    <= 8'd0;
            r_full    <= 1'b0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_hold    <= w_hold_next;
            r_full    <= w_full_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_ready   <= !w_full_next;
            r_busy    <= (w_state_next != S_IDLE) || w_full_next;
            r_overrun <= LOAD && r_full;
        end
    end

    assign READY   = r_ready;
    assign BUSY    = r_busy;
    assign OVERRUN = r_overrun;
    assign TX_D    = r_tx;

endmodule

// File: tb/tb_serial_out.sv
// Bench for serial_out: three instances (no parity, even, odd) at 4 clocks per bit,
// frames decoded off the line and compared against a per-instance expected-byte queue.
module tb_serial_out;

    localparam int CPB = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] byte_in [3];
    logic [2:0] load;
    wire  [2:0] ready, busy, ovr, tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt [3] = '{0, 0, 0};
    int start_cyc [3] = '{0, 0, 0};
    int prev_start [3] = '{0, 0, 0};
    int frames [3] = '{0, 0, 0};
    logic [8:0] exp_q [3][$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) if (ovr[k] === 1'b1) ovr_cnt[k]++;
    end

    serial_out #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .BYTEIN(byte_in[0]), .LOAD(load[0]),
        .READY(ready[0]), .BUSY(busy[0]), .OVERRUN(ovr[0]), .TX_D(tx[0]));

    serial_out #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .BYTEIN(byte_in[1]), .LOAD(load[1]),
        .READY(ready[1]), .BUSY(busy[1]), .OVERRUN(ovr[1]), .TX_D(tx[1]));

    serial_out #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .BYTEIN(byte_in[2]), .LOAD(load[2]),
        .READY(ready[2]), .BUSY(busy[2]), .OVERRUN(ovr[2]), .TX_D(tx[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decodes one frame per start bit; every bit must hold for exactly CPB samples.
    task automatic mon(input int k);
        int             nb;
        logic [CPB-1:0] smp;
        logic [10:0]    bits;
        logic           ok;
        logic           abort;
        logic [8:0]     e;
        nb = (k == 0) ? 10 : 11;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1 && tx[k] === 1'b0) begin
                prev_start[k] = start_cyc[k];
                start_cyc[k]  = cyc;
                abort = 1'b0;
                ok    = 1'b1;
                bits  = '0;
                smp   = '0;
                for (int b = 0; b < nb; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge CLK);
                        if (RESET !== 1'b1) abort = 1'b1;
                        smp[c] = tx[k];
                    end
                    if (abort) break;
                    bits[b] = smp[0];
                    if (smp !== {CPB{smp[0]}}) ok = 1'b0;
                end
                if (!abort) begin
                    frames[k]++;
                    check($sformatf("bit_stable%0d", k), ok, 1);
                    check($sformatf("sb_nonempty%0d", k), exp_q[k].size() != 0, 1);
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        check($sformatf("data%0d", k), bits[8:1], e[7:0]);
                        if (nb == 11) check($sformatf("parity%0d", k), bits[9], e[8]);
                        check($sformatf("stop%0d", k), bits[nb-1], 1);
                    end
                end
            end
        end
    endtask

    task automatic do_load(input int k, input logic [7:0] d, input logic push, output int lc);
        @(negedge CLK);
        byte_in[k] = d;
        load[k]    = 1'b1;
        lc         = cyc;
        if (push) exp_q[k].push_back({(^d) ^ (k == 2), d});
        @(negedge CLK);
        load[k] = 1'b0;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (ready[k] !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("ready_timeout", ready[k], 1);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] !== 1'b0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", busy[k], 0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, lc2, lp, lq, lr, obase;
        RESET = 1'b0;
        load  = '0;
        for (int k = 0; k < 3; k++) byte_in[k] = 8'h00;
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        repeat (3) @(negedge CLK);
        check("rst_hold", {tx[0], ready[0], busy[0], ovr[0]}, 4'b1100);
        RESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            check("rst_idle", {tx[0], ready[0], busy[0], ovr[0]}, 4'b1100);
        end

        // Single byte 0xA5; after edge n+k the cycle counter reads lc+k+1.
        do_load(0, 8'hA5, 1'b1, lc);
        check("ready_low_after_load", ready[0], 0);
        while (cyc < lc + 41) @(negedge CLK);
        check("busy_last_stop", busy[0], 1);
        @(negedge CLK);
        check("busy_after_frame", busy[0], 0);
        check("tx_idle_after_frame", tx[0], 1);
        check("start_latency", start_cyc[0] - lc, 2);
        repeat (2) @(negedge CLK);

        // Back to back: second start must follow the first by exactly one frame.
        obase = ovr_cnt[0];
        do_load(0, 8'h00, 1'b1, lc);
        wait_ready(0);
        do_load(0, 8'hFF, 1'b1, lc2);
        wait_idle(0);
        check("b2b_start_spacing", start_cyc[0] - prev_start[0], 10 * CPB);
        check("b2b_no_overrun", ovr_cnt[0] - obase, 0);
        check("b2b_frames", frames[0], 3);

        // Overrun: third load lands while the holding register is full.
        obase = ovr_cnt[0];
        do_load(0, 8'h11, 1'b1, lc);
        wait_ready(0);
        do_load(0, 8'h22, 1'b1, lc);
        do_load(0, 8'h33, 1'b0, lc);
        check("ovr_pulse", ovr[0], 1);
        @(negedge CLK);
        check("ovr_one_cycle", ovr[0], 0);
        wait_idle(0);
        check("ovr_count", ovr_cnt[0] - obase, 1);
        check("ovr_frames", frames[0], 5);

        // Parity: 0x07 has odd weight, so even parity gives 1 and odd parity gives 0.
        fork
            do_load(1, 8'h07, 1'b1, lp);
            do_load(2, 8'h07, 1'b1, lq);
        join
        while (cyc < lp + 45) @(negedge CLK);
        check("par_even_busy_last", busy[1], 1);
        check("par_odd_busy_last", busy[2], 1);
        @(negedge CLK);
        check("par_even_busy_done", busy[1], 0);
        check("par_odd_busy_done", busy[2], 0);
        do_load(1, 8'h3C, 1'b1, lp);
        wait_idle(1);
        check("par_frames_even", frames[1], 2);
        check("par_frames_odd", frames[2], 1);

        // Reset during data bit 3 (0xC3 has bit 3 low, so the line is low there).
        do_load(0, 8'hC3, 1'b0, lr);
        while (cyc < lr + 19) @(negedge CLK);
        check("pre_reset_tx", tx[0], 0);
        RESET = 1'b0;
        #1;
        check("reset_tx_async", tx[0], 1);
        check("reset_ready", ready[0], 1);
        check("reset_busy", busy[0], 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        check("post_reset_idle", {tx[0], ready[0], busy[0]}, 3'b110);
        do_load(0, 8'h5A, 1'b1, lc);
        wait_idle(0);
        check("post_reset_frames", frames[0], 6);

        for (int k = 0; k < 3; k++) check($sformatf("sb_drained%0d", k), exp_q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_out.md
# serial_out

UART-style asynchronous serial transmitter: accepts a parallel byte on a load strobe and shifts it out on a single line as start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Sits at the output side of the serial/SPI bridge, returning bytes from the SPI side to the host serial link. A one-byte holding register allows back-to-back frames with no idle gap between stop and next start.

## Interface
- CLKS_PER_BIT, 16: CLK cycles per serial bit period; legal range 2..65535.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.

- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BYTEIN  input  8  byte to transmit; sampled only on an accepted LOAD.
- LOAD  input  1  write strobe, one per byte; accepted when READY=1.
- READY  output  1  holding register empty; LOAD will be accepted.
- BUSY  output  1  frame in progress or holding register full.
- OVERRUN  output  1  one-cycle pulse: LOAD seen while READY=0; byte dropped.
- TX_D  output  1  serial line, registered, idles high.

## Operation
- Reset (RESET=0, immediate): TX_D=1, READY=1, BUSY=0, OVERRUN=0, state IDLE, bit and baud counters 0, holding register empty.
- Reset mid-frame aborts the frame; TX_D returns high asynchronously. No partial frame is resumed after reset.
- Holding register:
  - LOAD=1 with READY=1 captures BYTEIN and marks the register full.
  - LOAD=1 with READY=0 leaves the register unchanged and pulses OVERRUN for one cycle.
  - A transfer from the holding register to the shift register empties it. Transfer occurs in IDLE when full, or on the last cycle of STOP when full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_D=1. If the holding register is full, transfer and go to START.
  - START: TX_D=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TX_D = shift[0]; shift right every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: TX_D = XOR of the 8 data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles.
  - STOP: TX_D=1 for CLKS_PER_BIT cycles. On the last cycle, transfer and go to START if the holding register is full, else go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1, reloads to 0 on each bit boundary, and is held at 0 in IDLE.
- The bit counter is 3 bits; it wraps 7→0 on exit from DATA.
- BUSY = (state != IDLE) OR holding register full.
- Parity is computed from the byte latched at transfer, not from live BYTEIN.

## Timing
- LOAD accepted at rising edge n while IDLE:
  - READY=0 after edge n.
  - At edge n+1: transfer, READY=1, state START, TX_D=0.
  - Latency from LOAD edge to start-bit edge is 1 cycle.
- Frame length is (10+PARITY_EN)·CLKS_PER_BIT cycles. Each bit is exactly CLKS_PER_BIT cycles, with no jitter.
- Back-to-back: when the holding register is full at the last STOP cycle, the next start bit begins on the following edge. Line high time is exactly CLKS_PER_BIT cycles.
- Simultaneous transfer and LOAD in the same cycle: READY is still 0 in that cycle, so LOAD is rejected and OVERRUN pulses. Software must wait for READY=1.
- OVERRUN is asserted on the cycle after the offending edge, for one cycle only.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset values: hold RESET=0, then release with no LOAD → TX_D=1, READY=1, BUSY=0, OVERRUN=0 for 100 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0: LOAD 0xA5 → TX_D sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Start edge 1 cycle after LOAD. BUSY=0 after 40 cycles.
- Back-to-back: LOAD 0x00, then LOAD 0xFF when READY returns to 1 → two 40-cycle frames with exactly 4 cycles high between them. No OVERRUN.
- Overrun: LOAD 0x11, LOAD 0x22 once READY=1, then LOAD 0x33 while READY=0 → OVERRUN pulses once. Line carries only 0x11 and 0x22.
- Parity, PARITY_EN=1: LOAD 0x07 with PARITY_ODD=0 → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert RESET during DATA bit 3 → TX_D=1 immediately and READY=1. After release, LOAD 0x5A transmits cleanly.
